// File: rtl/reg_file_if.sv
// reg_file_if: write and dual read port bundle for reg_file.
// Ports: We/Wn/D form the write port. Rna/Rnb select the read registers. Qa/Qb return the read data.
// Modports: the master drives the requests, and the slave (reg_file) drives Qa/Qb.
interface reg_file_if #(parameter int WIDTH = 32, parameter int AW = 5);
  logic             We;
  logic [AW-1:0]    Wn;
  logic [WIDTH-1:0] D;
  logic [AW-1:0]    Rna;
  logic [AW-1:0]    Rnb;
  logic [WIDTH-1:0] Qa;
  logic [WIDTH-1:0] Qb;
  modport master (output We, Wn, D, Rna, Rnb, input Qa, Qb);
  modport slave  (input We, Wn, D, Rna, Rnb, output Qa, Qb);
endinterface

// File: rtl/reg_file.sv
// reg_file: register file with 2**AW registers of WIDTH bits, one write port and two combinational read ports.
// Ports: Clk is the clock. Clrn is an asynchronous active-low clear of all registers. bus is a reg_file_if slave.
// Register 0 is hardwired to read 0.
// Macro REGFILE_BYPASS_EN forwards write data D to a read port addressing Wn before the clock edge.
module reg_file #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input logic        Clk,
  input logic        Clrn,
  reg_file_if.slave  bus
);
  logic [WIDTH-1:0] regs [2**AW];
  logic             wr;
  assign wr = bus.We && (bus.Wn != '0);
  // Entry 0 is cleared by reset and is never written, so it always reads 0 after reset.
  always_ff @(posedge Clk or negedge Clrn)
    if (!Clrn)
      for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
    else if (wr)
      regs[bus.Wn] <= bus.D;
`ifdef REGFILE_BYPASS_EN
  // Forwarding is gated by Clrn, so a cleared file never exposes D.
  assign bus.Qa = (Clrn && wr && bus.Rna == bus.Wn) ? bus.D : regs[bus.Rna];
  assign bus.Qb = (Clrn && wr && bus.Rnb == bus.Wn) ? bus.D : regs[bus.Rnb];
`else
  assign bus.Qa = regs[bus.Rna];
  assign bus.Qb = regs[bus.Rnb];
`endif
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
module tb_reg_file;
  logic Clk = 1'b0;
  logic Clrn = 1'b0;
  int checks = 0;
  int failures = 0;
  reg_file_if #(.WIDTH(32), .AW(5)) bus ();
  reg_file #(.WIDTH(32), .AW(5)) dut (.Clk(Clk), .Clrn(Clrn), .bus(bus));
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [4:0] wn, input logic [31:0] d);
    @(negedge Clk);
    bus.We = 1'b1; bus.Wn = wn; bus.D = d;
    @(posedge Clk);
    #1 bus.We = 1'b0;
  endtask
  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    bus.Rna = a; bus.Rnb = b;
    #1;
  endtask
  logic [31:0] pre;
  initial begin
`ifdef REGFILE_BYPASS_EN
    pre = 32'h5A5A5A5A;
`else
    pre = 32'hA5A5A5A5;
`endif
    bus.We = 1'b1; bus.Wn = 5'd2; bus.D = 32'hCAFEF00D; bus.Rna = 5'd2; bus.Rnb = 5'd0;
    #100;
    chk("reset_write_ignored", bus.Qa, 32'h0);
    rd(5'd1, 5'd31);
    chk("reset_qa", bus.Qa, 32'h0);
    chk("reset_qb", bus.Qb, 32'h0);
    bus.We = 1'b0;
    @(negedge Clk);
    Clrn = 1'b1;
    for (int i = 0; i < 32; i += 4) begin
      rd(5'(i), 5'(i + 3));
      chk("post_reset_qa", bus.Qa, 32'h0);
      chk("post_reset_qb", bus.Qb, 32'h0);
    end
    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd6);
    chk("write5_qa", bus.Qa, 32'hDEADBEEF);
    chk("write5_qb_r6", bus.Qb, 32'h0);
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd5);
    chk("r0_write_qa", bus.Qa, 32'h0);
    chk("r0_write_r5", bus.Qb, 32'hDEADBEEF);
    @(negedge Clk);
    bus.We = 1'b0; bus.Wn = 5'd5; bus.D = 32'h12345678;
    @(posedge Clk);
    #1 rd(5'd5, 5'd5);
    chk("we0_hold", bus.Qa, 32'hDEADBEEF);
    wr(5'd31, 32'h31313131);
    rd(5'd31, 5'd30);
    chk("write31_qa", bus.Qa, 32'h31313131);
    chk("write31_r30", bus.Qb, 32'h0);
    rd(5'd5, 5'd1);
    chk("isolate_r5", bus.Qa, 32'hDEADBEEF);
    chk("isolate_r1", bus.Qb, 32'h0);
    wr(5'd7, 32'hA5A5A5A5);
    @(negedge Clk);
    bus.Rna = 5'd7; bus.Rnb = 5'd7; bus.Wn = 5'd7; bus.We = 1'b1; bus.D = 32'h5A5A5A5A;
    #1;
    chk("same_idx_pre_qa", bus.Qa, pre);
    chk("same_idx_pre_qb", bus.Qb, pre);
    @(posedge Clk);
    #1;
    chk("same_idx_post_qa", bus.Qa, 32'h5A5A5A5A);
    chk("same_idx_post_qb", bus.Qb, 32'h5A5A5A5A);
    @(negedge Clk);
    bus.Wn = 5'd0; bus.D = 32'hFFFFFFFF; bus.Rna = 5'd0; bus.Rnb = 5'd7;
    #1;
    chk("no_fwd_r0", bus.Qa, 32'h0);
    chk("fwd_other_idx", bus.Qb, 32'h5A5A5A5A);
    bus.We = 1'b0;
    wr(5'd3, 32'h1);
    rd(5'd3, 5'd7);
    chk("write3", bus.Qa, 32'h1);
    @(negedge Clk);
    #1 Clrn = 1'b0;
    bus.We = 1'b1; bus.Wn = 5'd3; bus.D = 32'h99999999;
    #1;
    chk("clr_async_qa", bus.Qa, 32'h0);
    chk("clr_async_qb", bus.Qb, 32'h0);
    bus.We = 1'b0;
    #1 Clrn = 1'b1;
    @(posedge Clk);
    #1 rd(5'd3, 5'd31);
    chk("clr_r3_stays0", bus.Qa, 32'h0);
    chk("clr_r31_stays0", bus.Qb, 32'h0);
    wr(5'd3, 32'h00000077);
    rd(5'd3, 5'd5);
    chk("rewrite3", bus.Qa, 32'h00000077);
    chk("rewrite_r5_cleared", bus.Qb, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: WIDTH, 32, data width of each register in bits.
REQ-002 Parameter: AW, 5, address width; register count is 2**AW.
REQ-003 Port: Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: Clrn  input  1  asynchronous, active-low reset (clear) of all registers.
REQ-005 Port: We  input  1  write enable, sampled at the rising edge of Clk.
REQ-006 Port: Wn  input  AW  write register number.
REQ-007 Port: D  input  WIDTH  write data.
REQ-008 Port: Rna  input  AW  read port A register number.
REQ-009 Port: Rnb  input  AW  read port B register number.
REQ-010 Port: Qa  output  WIDTH  read port A data.
REQ-011 Port: Qb  output  WIDTH  read port B data.

Function
REQ-012 Storage SHALL be 2**AW registers of WIDTH bits; register 0 SHALL always read 0.
REQ-013 On the rising edge of Clk with Clrn=1, We=1 and Wn!=0, reg[Wn] SHALL load D.
REQ-014 If We=0, or Wn=0, or Clrn=0, no register SHALL change at the clock edge.
REQ-015 Read ports SHALL be combinational: Qa=reg[Rna] and Qb=reg[Rnb] within the same cycle, with zero clock latency.
REQ-016 Both ports SHALL read the same register simultaneously without conflict, including Rna=Rnb=Wn.
REQ-017 A write is visible on Qa/Qb immediately after the rising edge that performs it.
REQ-018 Read and write to the same index in one cycle (bypass disabled): Qa/Qb SHALL show the old value until the edge, then the new value.
REQ-019 Writes SHALL have no effect on any register other than reg[Wn].
REQ-020 Outputs SHALL never be X once Clrn has been asserted at least once, for any Rna/Rnb value.

Reset
REQ-021 Clrn=0 SHALL clear every register to 0 immediately, independent of Clk.
REQ-022 While Clrn=0, Qa and Qb SHALL be 0 for all addresses, and writes SHALL be ignored.
REQ-023 Clrn falling mid-cycle after a write SHALL discard that written value; Clrn rising SHALL NOT cause a write; the first write is taken on the next rising edge with Clrn=1.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN SHALL enable write-to-read forwarding.
REQ-025 With REGFILE_BYPASS_EN defined: if Clrn=1, We=1, Wn!=0 and Rna=Wn (or Rnb=Wn), Qa (or Qb) SHALL show D combinationally in the same cycle, before the edge.
REQ-026 With REGFILE_BYPASS_EN undefined: reads SHALL return stored contents only, as in REQ-018.
REQ-027 Bypass SHALL never forward to register 0 and SHALL be disabled while Clrn=0.

Verification
REQ-028 Clrn=0 for 100 ns, then Rna=1, Rnb=31 -> Qa=0, Qb=0.
REQ-029 Clrn=1, We=1, Wn=5, D=32'hDEADBEEF, one edge; then Rna=5 -> Qa=32'hDEADBEEF; Rnb=6 -> Qb=0.
REQ-030 We=1, Wn=0, D=32'hFFFFFFFF, one edge; Rna=0 -> Qa=0.
REQ-031 We=0, Wn=5, D=32'h12345678, one edge; Rna=5 -> Qa still 32'hDEADBEEF.
REQ-032 reg[7]=32'hA5A5A5A5; Rna=Rnb=Wn=7, We=1, D=32'h5A5A5A5A -> before edge: Qa=Qb=32'hA5A5A5A5 (no bypass) or 32'h5A5A5A5A (REGFILE_BYPASS_EN); after edge: both 32'h5A5A5A5A.
REQ-033 Write reg[3]=32'h1; Clrn=0 pulse between clock edges -> Qa (Rna=3)=0 immediately; reg[3] stays 0 after Clrn=1 until rewritten.
